// File: rtl/cam_8x8b_1s1w_pkg.sv
// Shared sizing constants and payload types for the 8x8 CAM.
package cam_8x8b_1s1w_pkg;

   localparam int unsigned NUM_ENTRIES = 8;
   localparam int unsigned DATA_WIDTH  = 8;
   localparam int unsigned ADDR_WIDTH  = 3;

   typedef logic [DATA_WIDTH-1:0]  data_t;
   typedef logic [ADDR_WIDTH-1:0]  addr_t;
   typedef logic [NUM_ENTRIES-1:0] match_t;

endpackage : cam_8x8b_1s1w_pkg

// File: rtl/cam_8x8b_1s1w_entry.sv
// One CAM word: a resettable register plus its search comparator.
module cam_8x8b_1s1w_entry
   import cam_8x8b_1s1w_pkg::*;
(
   input  logic  clk,
   input  logic  reset,
   input  logic  write_en_i,
   input  data_t write_data_i,
   input  logic  search_en_i,
   input  data_t search_data_i,
   output logic  match_o
);

   data_t data_q;
   data_t data_d;

   always_comb begin
      data_d = data_q;
      if (write_en_i) begin
         data_d = write_data_i;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         data_q <= DATA_WIDTH'(0);
      end else begin
         data_q <= data_d;
      end
   end

   // Compares against the pre-edge contents, so a same-cycle write is not visible.
   assign match_o = search_en_i && (data_q == search_data_i);

endmodule : cam_8x8b_1s1w_entry

// File: rtl/cam_8x8b_1s1w.sv
// 8-entry x 8-bit CAM: one synchronous write port, one combinational multi-hot search port.
module cam_8x8b_1s1w
   import cam_8x8b_1s1w_pkg::*;
(
   input  logic   clk,
   input  logic   reset,
   input  logic   write_en,
   input  addr_t  write_addr,
   input  data_t  write_data,
   input  logic   search_en,
   input  data_t  search_data,
   output match_t search_match
);

   match_t wr_sel;
   match_t hit;

   // Write-address decoder: at most one entry enabled per cycle.
   always_comb begin
      wr_sel = '0;
      if (write_en) begin
         wr_sel[write_addr] = 1'b1;
      end
   end

   for (genvar g = 0; g < NUM_ENTRIES; g++) begin : g_entry
      cam_8x8b_1s1w_entry u_entry (
         .clk           (clk),
         .reset         (reset),
         .write_en_i    (wr_sel[g]),
         .write_data_i  (write_data),
         .search_en_i   (search_en),
         .search_data_i (search_data),
         .match_o       (hit[g])
      );
   end

   assign search_match = hit;

endmodule : cam_8x8b_1s1w

// File: tb/tb_cam_8x8b_1s1w.sv
// Scoreboard bench for cam_8x8b_1s1w: stimulus queues expectations, a negedge monitor checks them.
module tb_cam_8x8b_1s1w;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       write_en = 1'b0;
   logic [2:0] write_addr = 3'd0;
   logic [7:0] write_data = 8'h00;
   logic       search_en = 1'b0;
   logic [7:0] search_data = 8'h00;
   logic [7:0] search_match;

   logic       chk = 1'b0;
   logic       done = 1'b0;
   logic       mon_done = 1'b0;

   logic [7:0] exp_q[$];
   string      name_q[$];
   logic [7:0] mdl [8];

   int total = 0;
   int bad   = 0;

   cam_8x8b_1s1w dut (
      .clk          (clk),
      .reset        (reset),
      .write_en     (write_en),
      .write_addr   (write_addr),
      .write_data   (write_data),
      .search_en    (search_en),
      .search_data  (search_data),
      .search_match (search_match)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] model_match(input logic se, input logic [7:0] sd);
      logic [7:0] m;
      m = 8'h00;
      for (int i = 0; i < 8; i++) begin
         m[i] = se && (mdl[i] == sd);
      end
      return m;
   endfunction

   // Apply one cycle of inputs, optionally queue an expectation, then advance the model past the edge.
   task automatic step(input logic rst, input logic we, input logic [2:0] a, input logic [7:0] wd,
                       input logic se, input logic [7:0] sd, input logic do_chk,
                       input logic [7:0] exp_v, input string nm);
      reset       = rst;
      write_en    = we;
      write_addr  = a;
      write_data  = wd;
      search_en   = se;
      search_data = sd;
      chk         = do_chk;
      if (do_chk) begin
         exp_q.push_back(exp_v);
         name_q.push_back(nm);
      end
      @(posedge clk);
      if (rst) begin
         for (int i = 0; i < 8; i++) mdl[i] = 8'h00;
      end else if (we) begin
         mdl[a] = wd;
      end
      #1;
   endtask

   task automatic wr(input logic [2:0] a, input logic [7:0] wd);
      step(1'b0, 1'b1, a, wd, 1'b0, 8'h00, 1'b0, 8'h00, "");
   endtask

   task automatic srch(input logic [7:0] sd, input logic [7:0] exp_v, input string nm);
      step(1'b0, 1'b0, 3'd0, 8'h00, 1'b1, sd, 1'b1, exp_v, nm);
   endtask

   // Monitor: every flagged cycle pops one expectation and compares mid-cycle.
   always @(negedge clk) begin
      if (chk) begin
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL underflow: got %h, no expectation queued", search_match);
         end else begin
            automatic logic [7:0] e = exp_q.pop_front();
            automatic string n = name_q.pop_front();
            if (search_match !== e) begin
               bad++;
               $display("FAIL %s: got %h required %h", n, search_match, e);
            end
         end
      end
      if (done && !mon_done) begin
         total++;
         if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d left, required 0", exp_q.size());
         end
         mon_done <= 1'b1;
      end
   end

   initial begin
      logic [7:0] t2_data [8];
      logic [7:0] t3_data [8];
      t2_data = '{8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB, 8'hCD, 8'hEF};
      t3_data = '{8'h01, 8'h23, 8'hAB, 8'h23, 8'h89, 8'hAB, 8'h23, 8'hEF};
      for (int i = 0; i < 8; i++) mdl[i] = 8'h00;

      @(posedge clk); #1;
      // Reset with a write attempt that must be ignored; search disabled reads zero.
      step(1'b1, 1'b1, 3'd2, 8'h5A, 1'b0, 8'h5A, 1'b1, 8'h00, "rst_se0");
      step(1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, "");
      srch(8'h00, 8'hFF, "rst_all_zero");
      srch(8'h5A, 8'h00, "rst_write_ignored");
      step(1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 8'h00, 1'b1, 8'h00, "se0_zero");

      // Distinct values: one-hot per address.
      for (int i = 0; i < 8; i++) wr(3'(i), t2_data[i]);
      srch(8'h01, 8'h01, "onehot0");
      srch(8'h23, 8'h02, "onehot1");
      srch(8'h45, 8'h04, "onehot2");
      srch(8'h67, 8'h08, "onehot3");
      srch(8'h89, 8'h10, "onehot4");
      srch(8'hAB, 8'h20, "onehot5");
      srch(8'hCD, 8'h40, "onehot6");
      srch(8'hEF, 8'h80, "onehot7");
      step(1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 8'hEF, 1'b1, 8'h00, "se0_hit_masked");

      // Duplicates: multi-hot, no priority.
      for (int i = 0; i < 8; i++) wr(3'(i), t3_data[i]);
      srch(8'h23, 8'h4A, "multi_23");
      srch(8'hAB, 8'h24, "multi_ab");
      srch(8'h01, 8'h01, "multi_01");
      srch(8'hEF, 8'h80, "multi_ef");
      srch(8'h55, 8'h00, "miss_55");

      // Same-cycle write is not forwarded.
      step(1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, "");
      step(1'b0, 1'b1, 3'd0, 8'h01, 1'b1, 8'h01, 1'b1, 8'h00, "no_fwd");
      srch(8'h01, 8'h01, "after_write");

      // Overwrite keeps only the last value; writing 0x00 is legal.
      wr(3'd1, 8'hCD);
      wr(3'd1, 8'hEF);
      srch(8'hCD, 8'h00, "overwrite_old");
      srch(8'hEF, 8'h02, "overwrite_new");
      wr(3'd0, 8'h00);
      srch(8'h00, 8'hFD, "write_zero");

      // Random traffic against the behavioural model: narrow data first for collisions.
      for (int n = 0; n < 96; n++) begin
         logic       we, se;
         logic [2:0] a;
         logic [7:0] wd, sd;
         we = 1'($urandom_range(0, 1));
         se = 1'($urandom_range(0, 3) != 0);
         a  = 3'($urandom_range(0, 7));
         if (n < 48) begin
            wd = 8'($urandom_range(1, 4));
            sd = 8'($urandom_range(1, 4));
         end else begin
            wd = 8'($urandom_range(0, 255));
            sd = 8'($urandom_range(0, 255));
         end
         step(1'b0, we, a, wd, se, sd, 1'b1, model_match(se, sd), "random");
      end

      chk = 1'b0;
      write_en = 1'b0;
      search_en = 1'b0;
      done = 1'b1;
      for (int k = 0; k < 4 && !mon_done; k++) @(posedge clk);
      #1;
      if (!mon_done) begin
         $display("FAIL monitor_timeout: got done=0 required done=1");
         $fatal(1);
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_cam_8x8b_1s1w

// File: doc/cam_8x8b_1s1w.md
Name: cam_8x8b_1s1w

Overview:
- 8-entry × 8-bit content-addressable memory (CAM) with one synchronous write port and one combinational search port.
- A search compares search_data against all entries in parallel and returns a one-hot-or-multi-hot match vector.
- Used as a small tag/lookup structure; storage is flop-based.

Parameters:
- NUM_ENTRIES, 8, number of CAM entries; also the width of search_match.
- DATA_WIDTH, 8, width of each stored word and of search_data.
- ADDR_WIDTH, 3, write address width; equals clog2(NUM_ENTRIES).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- write_en  input  1  write enable.
- write_addr  input  3  entry index to write.
- write_data  input  8  value to store.
- search_en  input  1  search enable.
- search_data  input  8  value to search for.
- search_match  output  8  bit i = 1 iff search hits entry i.

Behaviour:
- Storage: 8 registers of 8 bits, mem[0..7].
- Reset (synchronous, active-high): all entries cleared to 8'h00 on the rising edge while reset=1. Writes are ignored during reset.
- Write: on a rising edge with write_en=1 and reset=0, mem[write_addr] <= write_data. All other entries are unchanged. With write_en=0, no entry changes.
- Search is purely combinational from the current (pre-edge) storage, with zero-cycle latency.
  - search_en=1: search_match[i] = (mem[i] == search_data) for every i.
  - search_en=0: search_match = 8'h00, regardless of storage or search_data.
- Multiple entries holding the same value: every matching bit is set (multi-hot). No priority encoding.
- No match: search_match = 8'h00.
- No write-to-search forwarding. A search in the same cycle as a write sees the old contents. The newly written value becomes searchable from the next cycle.
- Output during and after reset: search_match = 8'h00 while search_en=0. After reset, a search for 8'h00 with search_en=1 returns 8'hFF, since all entries are zero.
- Write data may be any 8-bit value, including 8'h00. Writing the same address repeatedly keeps only the last value. All 3-bit addresses are valid, so no out-of-range case exists.
- No handshake, no state machine.

Decomposition:
- Shared package: constants NUM_ENTRIES, DATA_WIDTH, ADDR_WIDTH, and typedefs data_t (logic [7:0]), addr_t (logic [2:0]), match_t (logic [7:0]).
- One natural sub-module: cam_entry. It holds one 8-bit register with write-enable and reset, plus an equality comparator output (match = en & (q == search_data)).
- The top instantiates NUM_ENTRIES copies of cam_entry, a 3-to-8 write-address decoder, and concatenates the match bits.

Test Plan:
1. Reset, then search_en=1 with search_data=8'h00 → search_match=8'hFF. Then search_en=0 → 8'h00.
2. Write 0x01,0x23,0x45,0x67,0x89,0xAB,0xCD,0xEF to addrs 0–7, then search each in turn → one-hot outputs 8'h01, 8'h02, 8'h04 … 8'h80 respectively.
3. Multi-match: store {0x01,0x23,0xAB,0x23,0x89,0xAB,0x23,0xEF} in addrs 0–7.
   - search 0x23 → 8'h4A
   - search 0xAB → 8'h24
   - search 0x01 → 8'h01
   - search 0xEF → 8'h80
   - search 0x55 → 8'h00
4. No forwarding: after clearing all entries, drive write_en=1, addr=0, data=0x01 together with search_en=1, search_data=0x01 in the same cycle → search_match=8'h00. The next cycle, a search for 0x01 → 8'h01.
5. Overwrite: write 0xCD to addr 1, then 0xEF to addr 1.
   - search 0xCD → 8'h00
   - search 0xEF → 8'h02
6. Random: 40+ cycles of random write_en, addr, data and search_en, data (data constrained to 1–4 to force collisions, then fully random), compared every cycle against a behavioural model implementing the rules above.
